// File: rtl/eth_tx_frame_packer.sv
// Packs the MMIO transmit word stream (length header + data words) into AXI-Stream
// beats for the MAC TX FIFO, generating tkeep/tlast and the exported TX state.
module eth_tx_frame_packer #(
    parameter int axis_data_width_p = 64,
    parameter int len_width_p       = 11,
    parameter int max_len_p         = 1522
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [axis_data_width_p-1:0]   frame_data_i,
    input  logic                           frame_data_v_i,
    output logic                           frame_data_yumi_o,
    output logic [axis_data_width_p-1:0]   tx_axis_tdata_o,
    output logic [axis_data_width_p/8-1:0] tx_axis_tkeep_o,
    output logic                           tx_axis_tvalid_o,
    input  logic                           tx_axis_tready_i,
    output logic                           tx_axis_tlast_o,
    output logic                           tx_axis_tuser_o,
    output logic [1:0]                     tx_ext_state_o,
    output logic                           frame_done_o,
    output logic                           err_len_o
);

    localparam int keep_w_lp  = axis_data_width_p / 8;
    localparam int tail_w_lp  = $clog2(keep_w_lp);
    localparam int beats_w_lp = len_width_p - tail_w_lp + 1;
    localparam logic [len_width_p:0] max_len_lp = (len_width_p + 1)'(max_len_p);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e                         state_q;
    logic [beats_w_lp-1:0]          beats_q;
    logic [tail_w_lp-1:0]           tail_q;
    logic [axis_data_width_p-1:0]   tdata_q;
    logic [keep_w_lp-1:0]           tkeep_q;
    logic                           tvalid_q;
    logic                           tlast_q;
    logic                           frame_done_q;
    logic                           err_len_q;

    logic [len_width_p-1:0]         hdr_len;
    logic                           hdr_bad;
    logic [beats_w_lp-1:0]          beats_d;
    logic                           handshake;
    logic                           accept;
    logic                           last_word;
    logic [keep_w_lp-1:0]           tail_keep_d;
    logic                           yumi_d;

    assign hdr_len   = frame_data_i[len_width_p-1:0];
    assign hdr_bad   = (hdr_len == '0) || ({1'b0, hdr_len} > max_len_lp);
    // ceil(L/8) without carrying unused low bits of an L+7 sum
    assign beats_d   = {1'b0, hdr_len[len_width_p-1:tail_w_lp]}
                     + beats_w_lp'(|hdr_len[tail_w_lp-1:0]);
    assign handshake = tvalid_q & tx_axis_tready_i;
    assign accept    = frame_data_v_i & (~tvalid_q | tx_axis_tready_i);
    assign last_word = (beats_q == beats_w_lp'(1));

    always_comb begin
        tail_keep_d = '1;
        if (tail_q != '0) begin
            tail_keep_d = (keep_w_lp'(1) << tail_q) - keep_w_lp'(1);
        end
    end

    always_comb begin
        yumi_d = 1'b0;
        case (state_q)
            ST_IDLE: yumi_d = frame_data_v_i;
            ST_DATA: yumi_d = accept;
            default: yumi_d = 1'b0;
        endcase
    end

    assign frame_data_yumi_o = yumi_d & reset_n_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            beats_q      <= '0;
            tail_q       <= '0;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_len_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            err_len_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (frame_data_v_i) begin
                        if (hdr_bad) begin
                            err_len_q <= 1'b1;
                        end else begin
                            beats_q <= beats_d;
                            tail_q  <= hdr_len[tail_w_lp-1:0];
                            state_q <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (accept) begin
                        tdata_q  <= frame_data_i;
                        tvalid_q <= 1'b1;
                        tlast_q  <= last_word;
                        tkeep_q  <= last_word ? tail_keep_d : '1;
                        if (last_word) begin
                            state_q <= ST_FLUSH;
                        end else begin
                            beats_q <= beats_q - beats_w_lp'(1);
                        end
                    end else if (handshake) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        tkeep_q  <= '0;
                    end
                end
                ST_FLUSH: begin
                    // final beat held until the MAC takes it; no header is taken meanwhile
                    if (handshake) begin
                        tvalid_q     <= 1'b0;
                        tlast_q      <= 1'b0;
                        tkeep_q      <= '0;
                        frame_done_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_axis_tdata_o  = tdata_q;
    assign tx_axis_tkeep_o  = tkeep_q;
    assign tx_axis_tvalid_o = tvalid_q;
    assign tx_axis_tlast_o  = tlast_q;
    assign tx_axis_tuser_o  = 1'b0;
    assign tx_ext_state_o   = state_q;
    assign frame_done_o     = frame_done_q;
    assign err_len_o        = err_len_q;

endmodule

// File: tb/tb_eth_tx_frame_packer.sv
// Directed bench for eth_tx_frame_packer: a table of frames (good and rejected
// headers) plus hand-written FLUSH back-pressure, valid-drop and reset-abort sequences.
module tb_eth_tx_frame_packer;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [63:0] frame_data_i;
    logic        frame_data_v_i;
    logic        frame_data_yumi_o;
    logic [63:0] tx_axis_tdata_o;
    logic [7:0]  tx_axis_tkeep_o;
    logic        tx_axis_tvalid_o;
    logic        tx_axis_tready_i;
    logic        tx_axis_tlast_o;
    logic        tx_axis_tuser_o;
    logic [1:0]  tx_ext_state_o;
    logic        frame_done_o;
    logic        err_len_o;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    eth_tx_frame_packer dut (
        .clk_i             (clk_i),
        .reset_n_i         (reset_n_i),
        .frame_data_i      (frame_data_i),
        .frame_data_v_i    (frame_data_v_i),
        .frame_data_yumi_o (frame_data_yumi_o),
        .tx_axis_tdata_o   (tx_axis_tdata_o),
        .tx_axis_tkeep_o   (tx_axis_tkeep_o),
        .tx_axis_tvalid_o  (tx_axis_tvalid_o),
        .tx_axis_tready_i  (tx_axis_tready_i),
        .tx_axis_tlast_o   (tx_axis_tlast_o),
        .tx_axis_tuser_o   (tx_axis_tuser_o),
        .tx_ext_state_o    (tx_ext_state_o),
        .frame_done_o      (frame_done_o),
        .err_len_o         (err_len_o)
    );

    typedef struct {
        int         len;
        bit         toggle;
        int         nbeats;     // 0 means the header must be rejected
        logic [7:0] last_keep;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] word(input int len, input int i);
        return {16'(len), 16'(i), 32'h5A5A_0000 ^ 32'(i * 3 + len)};
    endfunction

    task automatic run_bad(input int len);
        frame_data_v_i   = 1'b1;
        frame_data_i     = 64'(len);
        tx_axis_tready_i = 1'b1;
        #1;
        chk("bad_yumi", 64'(frame_data_yumi_o), 64'd1);
        tick();
        frame_data_v_i = 1'b0;
        chk("bad_err_pulse", 64'(err_len_o), 64'd1);
        chk("bad_state", 64'(tx_ext_state_o), 64'd0);
        chk("bad_tvalid", 64'(tx_axis_tvalid_o), 64'd0);
        tick();
        chk("bad_err_clear", 64'(err_len_o), 64'd0);
        chk("bad_tvalid2", 64'(tx_axis_tvalid_o), 64'd0);
    endtask

    task automatic run_frame(input int len, input bit tog, input int nbeats,
                             input logic [7:0] last_keep);
        int          sent, recv, hdr_cyc;
        bit          want_done, finished, yum, stall_prev;
        logic [63:0] held_data;
        logic [8:0]  held_kl;
        sent = 0; recv = 0; hdr_cyc = 0;
        want_done = 0; finished = 0; stall_prev = 0;
        held_data = '0; held_kl = '0;
        for (int t = 0; t < 3000 && !finished; t++) begin
            frame_data_v_i   = (sent <= nbeats);
            frame_data_i     = (sent == 0) ? 64'(len) : word(len, sent - 1);
            tx_axis_tready_i = tog ? cyc[0] : 1'b1;
            #1;
            if (stall_prev) begin
                chk("hold_data", tx_axis_tdata_o, held_data);
                chk("hold_keep_last", 64'({tx_axis_tkeep_o, tx_axis_tlast_o}), 64'(held_kl));
            end
            if (tx_axis_tvalid_o && !tx_axis_tready_i)
                chk("yumi_stall", 64'(frame_data_yumi_o), 64'd0);
            stall_prev = tx_axis_tvalid_o & ~tx_axis_tready_i;
            held_data  = tx_axis_tdata_o;
            held_kl    = {tx_axis_tkeep_o, tx_axis_tlast_o};
            if (tx_axis_tvalid_o && tx_axis_tready_i) begin
                chk("beat_data", tx_axis_tdata_o, word(len, recv));
                chk("beat_keep", 64'(tx_axis_tkeep_o),
                    64'((recv == nbeats - 1) ? last_keep : 8'hFF));
                chk("beat_last", 64'(tx_axis_tlast_o), 64'(recv == nbeats - 1));
                chk("beat_tuser", 64'(tx_axis_tuser_o), 64'd0);
                if (recv == nbeats - 1) begin
                    chk("last_state", 64'(tx_ext_state_o), 64'd2);
                    want_done = 1;
                end
                recv++;
            end
            yum = frame_data_yumi_o;
            tick();
            if (yum) begin
                if (sent == 0) begin
                    hdr_cyc = cyc;
                    chk("hdr_state", 64'(tx_ext_state_o), 64'd1);
                end
                sent++;
            end
            if (want_done) begin
                chk("frame_done", 64'(frame_done_o), 64'd1);
                chk("done_state", 64'(tx_ext_state_o), 64'd0);
                chk("done_tvalid", 64'(tx_axis_tvalid_o), 64'd0);
                chk("beat_count", 64'(recv), 64'(nbeats));
                if (!tog) chk("latency", 64'(cyc - hdr_cyc), 64'(nbeats + 1));
                finished = 1;
            end
        end
        if (!finished) chk("frame_timeout", 64'd0, 64'd1);
        frame_data_v_i = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{64,   1'b0, 8,   8'hFF});
        vecs.push_back('{61,   1'b0, 8,   8'h1F});
        vecs.push_back('{60,   1'b1, 8,   8'h0F});
        vecs.push_back('{0,    1'b0, 0,   8'h00});
        vecs.push_back('{1600, 1'b0, 0,   8'h00});
        vecs.push_back('{14,   1'b0, 2,   8'h3F});
        vecs.push_back('{1,    1'b1, 1,   8'h01});
        vecs.push_back('{1522, 1'b0, 191, 8'h03});
        vecs.push_back('{1523, 1'b0, 0,   8'h00});
        vecs.push_back('{2047, 1'b0, 0,   8'h00});
        vecs.push_back('{23,   1'b1, 3,   8'h7F});

        // reset state, with a valid word pending to show yumi is held off
        reset_n_i        = 1'b0;
        frame_data_v_i   = 1'b1;
        frame_data_i     = 64'd64;
        tx_axis_tready_i = 1'b0;
        #12;
        chk("rst_tvalid", 64'(tx_axis_tvalid_o), 64'd0);
        chk("rst_tlast", 64'(tx_axis_tlast_o), 64'd0);
        chk("rst_tkeep", 64'(tx_axis_tkeep_o), 64'd0);
        chk("rst_tdata", tx_axis_tdata_o, 64'd0);
        chk("rst_tuser", 64'(tx_axis_tuser_o), 64'd0);
        chk("rst_state", 64'(tx_ext_state_o), 64'd0);
        chk("rst_done", 64'(frame_done_o), 64'd0);
        chk("rst_err", 64'(err_len_o), 64'd0);
        chk("rst_yumi", 64'(frame_data_yumi_o), 64'd0);
        frame_data_v_i = 1'b0;
        tick();
        reset_n_i = 1'b1;
        tick();

        foreach (vecs[i]) begin
            if (vecs[i].nbeats == 0) run_bad(vecs[i].len);
            else run_frame(vecs[i].len, vecs[i].toggle, vecs[i].nbeats, vecs[i].last_keep);
        end

        // Header offered during FLUSH with tready low: held off until tlast handshake
        frame_data_v_i   = 1'b1;
        frame_data_i     = 64'd8;
        tx_axis_tready_i = 1'b0;
        #1;
        chk("f5_hdr_yumi", 64'(frame_data_yumi_o), 64'd1);
        tick();
        frame_data_i = word(8, 0);
        #1;
        chk("f5_word_yumi", 64'(frame_data_yumi_o), 64'd1);
        tick();
        frame_data_i = 64'd16;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("f5_flush_yumi", 64'(frame_data_yumi_o), 64'd0);
            chk("f5_flush_state", 64'(tx_ext_state_o), 64'd2);
            chk("f5_flush_last", 64'({tx_axis_tvalid_o, tx_axis_tlast_o, tx_axis_tkeep_o}),
                64'({1'b1, 1'b1, 8'hFF}));
            chk("f5_flush_data", tx_axis_tdata_o, word(8, 0));
            tick();
        end
        tx_axis_tready_i = 1'b1;
        #1;
        chk("f5_release_yumi", 64'(frame_data_yumi_o), 64'd0);
        tick();
        chk("f5_done", 64'(frame_done_o), 64'd1);
        chk("f5_idle", 64'(tx_ext_state_o), 64'd0);
        chk("f5_idle_yumi", 64'(frame_data_yumi_o), 64'd1);
        tick();
        chk("f5_hdr2_state", 64'(tx_ext_state_o), 64'd1);

        // Non-final beat taken with no new word: tvalid must fall
        frame_data_i = word(16, 0);
        #1;
        chk("vd_word0_yumi", 64'(frame_data_yumi_o), 64'd1);
        tick();
        frame_data_v_i = 1'b0;
        chk("vd_beat0_valid", 64'(tx_axis_tvalid_o), 64'd1);
        chk("vd_beat0_data", tx_axis_tdata_o, word(16, 0));
        chk("vd_beat0_last", 64'(tx_axis_tlast_o), 64'd0);
        tick();
        chk("vd_valid_drop", 64'(tx_axis_tvalid_o), 64'd0);
        frame_data_v_i = 1'b1;
        frame_data_i   = word(16, 1);
        tick();
        frame_data_v_i = 1'b0;
        chk("vd_beat1", 64'({tx_axis_tvalid_o, tx_axis_tlast_o, tx_axis_tkeep_o}),
            64'({1'b1, 1'b1, 8'hFF}));
        chk("vd_beat1_data", tx_axis_tdata_o, word(16, 1));
        chk("vd_beat1_state", 64'(tx_ext_state_o), 64'd2);
        tick();
        chk("vd_done", 64'(frame_done_o), 64'd1);
        chk("vd_idle", 64'(tx_ext_state_o), 64'd0);

        // Reset asserted while beat 3 of 8 is on the output
        frame_data_v_i   = 1'b1;
        frame_data_i     = 64'd64;
        tx_axis_tready_i = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            frame_data_i = word(64, k);
            tick();
        end
        chk("ab_beat3_valid", 64'(tx_axis_tvalid_o), 64'd1);
        chk("ab_beat3_data", tx_axis_tdata_o, word(64, 2));
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("ab_tvalid", 64'(tx_axis_tvalid_o), 64'd0);
        chk("ab_tlast", 64'(tx_axis_tlast_o), 64'd0);
        chk("ab_tkeep", 64'(tx_axis_tkeep_o), 64'd0);
        chk("ab_tdata", tx_axis_tdata_o, 64'd0);
        chk("ab_state", 64'(tx_ext_state_o), 64'd0);
        chk("ab_yumi", 64'(frame_data_yumi_o), 64'd0);
        chk("ab_done", 64'(frame_done_o), 64'd0);
        frame_data_v_i = 1'b0;
        tick();
        reset_n_i = 1'b1;
        tick();
        run_frame(8, 1'b0, 1, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
